// File: rtl/fetch_unit.sv
// Instruction-fetch and next-PC stage: owns the PC, fetches over a req/ready
// handshake, holds the instruction until execute completes it, then redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        ex_done,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        branch,
    input  logic        brchne,
    input  logic        bgtz,
    input  logic        bltz,
    input  logic        blez,
    input  logic        alu_zero,
    input  logic [31:0] rs_val,
    output logic        misaligned,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;
    logic        taken;
    logic        rs_zero;
    logic        rs_neg;

    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[31:26];
    assign imem_addr = pc;
    assign imem_req  = (state == S_FETCH);

    // Priority jr > j > taken branch > fall-through; lower-priority inputs are
    // never consulted once a higher one is set, so X on them is harmless.
    always_comb begin
        rs_zero       = (rs_val == 32'd0);
        rs_neg        = rs_val[31];
        branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        taken         = (branch & alu_zero)
                      | (brchne & ~alu_zero)
                      | (bgtz & ~rs_neg & ~rs_zero)
                      | (blez & (rs_neg | rs_zero))
                      | (bltz & rs_neg);
        next_pc       = pc_plus4;
        if (jump_reg) begin
            next_pc = {rs_val[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_RESET;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            misaligned <= 1'b0;
            case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ex_done) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + 32'd1;
                        misaligned  <= jump_reg & (|rs_val[1:0]);
                        state       <= S_FETCH;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, handshake stalls, branch/jump
// redirects, PC wrap and mid-fetch reset, against hand-computed addresses.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    localparam logic [6:0] C_NONE = 7'b000_0000;
    localparam logic [6:0] C_JR   = 7'b100_0000;
    localparam logic [6:0] C_J    = 7'b010_0000;
    localparam logic [6:0] C_BEQ  = 7'b001_0000;
    localparam logic [6:0] C_BNE  = 7'b000_1000;
    localparam logic [6:0] C_BGTZ = 7'b000_0100;
    localparam logic [6:0] C_BLTZ = 7'b000_0010;
    localparam logic [6:0] C_BLEZ = 7'b000_0001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ex_done = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        branch = 1'b0;
    logic        brchne = 1'b0;
    logic        bgtz = 1'b0;
    logic        bltz = 1'b0;
    logic        blez = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] rs_val = 32'd0;
    logic        misaligned;
    logic [31:0] instr_count;

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] expPc;
    logic [31:0] expCount;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .ex_done    (ex_done),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .branch     (branch),
        .brchne     (brchne),
        .bgtz       (bgtz),
        .bltz       (bltz),
        .blez       (blez),
        .alu_zero   (alu_zero),
        .rs_val     (rs_val),
        .misaligned (misaligned),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic done, input logic [6:0] ctrl,
                                 input logic zero, input logic [31:0] rs);
        ex_done  = done;
        jump_reg = ctrl[6];
        jump     = ctrl[5];
        branch   = ctrl[4];
        brchne   = ctrl[3];
        bgtz     = ctrl[2];
        bltz     = ctrl[1];
        blez     = ctrl[0];
        alu_zero = zero;
        rs_val   = rs;
    endtask

    // Entered one step after a rising edge while the DUT sits in S_FETCH.
    task automatic fetchInstr(input logic [31:0] word, input int delay);
        for (int i = 0; i < delay; i++) begin
            checkOutput("stall_req", {31'd0, imem_req}, 32'd1);
            checkOutput("stall_addr", imem_addr, expPc);
            @(posedge clk); #1;
        end
        checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
        checkOutput("fetch_addr", imem_addr, expPc);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        checkOutput("hold_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("hold_instr", instr, word);
        checkOutput("hold_req", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic completeInstr(input string tag, input logic [6:0] ctrl, input logic zero,
                                 input logic [31:0] rs, input logic [31:0] expNext,
                                 input logic expMis);
        applyStimulus(1'b1, ctrl, zero, rs);
        @(posedge clk); #1;
        applyStimulus(1'b0, C_NONE, 1'b0, 32'd0);
        expCount = expCount + 32'd1;
        expPc    = expNext;
        checkOutput(tag, imem_addr, expNext);
        checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        checkOutput({tag, "_count"}, instr_count, expCount);
        checkOutput({tag, "_mis"}, {31'd0, misaligned}, {31'd0, expMis});
    endtask

    task automatic gotoPc(input logic [31:0] addr);
        fetchInstr(32'h03E0_0008, 0);
        completeInstr("goto", C_JR, 1'b0, addr, addr, 1'b0);
    endtask

    // beq/bne-style word with imm = -2 at pc 0x100: taken lands on 0xFC.
    task automatic runBranch(input string tag, input logic [6:0] ctrl, input logic zero,
                             input logic [31:0] rs, input logic tk);
        gotoPc(32'h0000_0100);
        fetchInstr(32'h1000_FFFE, 0);
        checkOutput({tag, "_pc4"}, pc_plus4, 32'h0000_0104);
        completeInstr(tag, ctrl, zero, rs, tk ? 32'h0000_00FC : 32'h0000_0104, 1'b0);
    endtask

    initial begin
        expPc    = RST_PC;
        expCount = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_pc", pc, RST_PC);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_count", instr_count, 32'd0);
        checkOutput("rst_mis", {31'd0, misaligned}, 32'd0);

        @(negedge clk);
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        #1;
        checkOutput("rel_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, 32'h0000_0040);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        checkOutput("first_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("first_instr", instr, 32'h2008_0005);
        checkOutput("first_opcode", {26'd0, opcode}, 32'h0000_0008);
        checkOutput("first_pc4", pc_plus4, 32'h0000_0044);

        // Control inputs without ex_done must not disturb the held instruction.
        applyStimulus(1'b0, C_J, 1'b1, 32'h0000_0203);
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("idle_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("idle_pc", pc, 32'h0000_0040);
            checkOutput("idle_count", instr_count, 32'd0);
        end
        applyStimulus(1'b0, C_NONE, 1'b0, 32'd0);
        completeInstr("seq", C_NONE, 1'b0, 32'd0, 32'h0000_0044, 1'b0);

        applyStimulus(1'b1, C_J, 1'b0, 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b0, C_NONE, 1'b0, 32'd0);
        checkOutput("exdone_fetch_count", instr_count, 32'd1);
        checkOutput("exdone_fetch_addr", imem_addr, 32'h0000_0044);

        fetchInstr(32'h0800_0040, 3);
        completeInstr("j_0x100", C_J, 1'b0, 32'd0, 32'h0000_0100, 1'b0);

        runBranch("beq_z1", C_BEQ, 1'b1, 32'd0, 1'b1);
        runBranch("beq_z0", C_BEQ, 1'b0, 32'd0, 1'b0);
        runBranch("bne_z1", C_BNE, 1'b1, 32'd0, 1'b0);
        runBranch("bne_z0", C_BNE, 1'b0, 32'd0, 1'b1);
        runBranch("bgtz_0", C_BGTZ, 1'b0, 32'h0000_0000, 1'b0);
        runBranch("bgtz_1", C_BGTZ, 1'b0, 32'h0000_0001, 1'b1);
        runBranch("bgtz_neg", C_BGTZ, 1'b0, 32'h8000_0000, 1'b0);
        runBranch("blez_0", C_BLEZ, 1'b0, 32'h0000_0000, 1'b1);
        runBranch("blez_1", C_BLEZ, 1'b0, 32'h0000_0001, 1'b0);
        runBranch("blez_neg", C_BLEZ, 1'b0, 32'h8000_0000, 1'b1);
        runBranch("bltz_0", C_BLTZ, 1'b0, 32'h0000_0000, 1'b0);
        runBranch("bltz_1", C_BLTZ, 1'b0, 32'h0000_0001, 1'b0);
        runBranch("bltz_neg", C_BLTZ, 1'b0, 32'h8000_0000, 1'b1);

        // j with branch inputs also asserted: jump must win.
        gotoPc(32'h1000_0000);
        fetchInstr(32'h0800_0010, 0);
        completeInstr("j_hi", C_J | C_BEQ | C_BNE, 1'b1, 32'd0, 32'h1000_0040, 1'b0);

        // jr over j, misaligned target.
        fetchInstr(32'h03E0_0008, 1);
        completeInstr("jr_mis", C_JR | C_J, 1'b0, 32'h0000_0203, 32'h0000_0200, 1'b1);
        @(posedge clk); #1;
        checkOutput("jr_mis_pulse", {31'd0, misaligned}, 32'd0);
        checkOutput("jr_mis_addr", imem_addr, 32'h0000_0200);

        gotoPc(32'hFFFF_FFFC);
        fetchInstr(32'h0000_0000, 0);
        checkOutput("wrap_pc4", pc_plus4, 32'h0000_0000);
        completeInstr("wrap", C_NONE, 1'b0, 32'd0, 32'h0000_0000, 1'b0);

        // Reset lands while a fetch is being accepted.
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2;
        reset_n = 1'b0;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        checkOutput("abort_instr", instr, 32'd0);
        checkOutput("abort_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("abort_pc", pc, RST_PC);
        checkOutput("abort_count", instr_count, 32'd0);
        checkOutput("abort_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_refetch", imem_addr, RST_PC);
        checkOutput("abort_refetch_req", {31'd0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
